// File: rtl/conv_host_8_4.sv
// Host side of the 8x4 convolver: loads x/f vectors, streams them out, and collects y results.
// Optional macro CONV_HOST_THROTTLE_EN adds LFSR-driven pacing of the valid/ready streams.
module conv_host_8_4 #(
    parameter int XLEN = 8,
    parameter int FLEN = 4,
    parameter int DW   = 8,
    parameter int YW   = 18,
    parameter int LOGX = 3,
    parameter int LOGF = 2,
    parameter int LOGY = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_en,
    input  logic            ld_sel,
    input  logic [LOGX-1:0] ld_addr,
    input  logic [DW-1:0]   ld_data,
    input  logic            start,
    output logic [DW-1:0]   m_data_out_x,
    output logic            m_valid_x,
    input  logic            m_ready_x,
    output logic [DW-1:0]   m_data_out_f,
    output logic            m_valid_f,
    input  logic            m_ready_f,
    input  logic [YW-1:0]   s_data_in_y,
    input  logic            s_valid_y,
    output logic            s_ready_y,
    input  logic [LOGY-1:0] rd_addr,
    output logic [YW-1:0]   rd_data,
    output logic            busy,
    output logic            done
);

    localparam int YLEN = XLEN - FLEN + 1;

    // Counters carry one extra bit so they can hold their terminal value.
    localparam logic [LOGX:0] X_END  = (LOGX+1)'(XLEN);
    localparam logic [LOGX:0] XF_END = (LOGX+1)'(FLEN);
    localparam logic [LOGF:0] F_END  = (LOGF+1)'(FLEN);
    localparam logic [LOGY:0] Y_END  = (LOGY+1)'(YLEN);
    localparam logic [LOGX:0] X_ONE  = (LOGX+1)'(1);
    localparam logic [LOGF:0] F_ONE  = (LOGF+1)'(1);
    localparam logic [LOGY:0] Y_ONE  = (LOGY+1)'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t        state_reg;
    logic [LOGX:0] x_cnt_reg;
    logic [LOGF:0] f_cnt_reg;
    logic [LOGY:0] y_cnt_reg;

    logic [DW-1:0] xbuf [0:(1<<LOGX)-1];
    logic [DW-1:0] fbuf [0:(1<<LOGF)-1];
    logic [YW-1:0] ybuf [0:(1<<LOGY)-1];

    logic run;
    logic x_more;
    logic f_more;
    logic y_room;
    logic x_fire;
    logic f_fire;
    logic y_fire;

    assign run    = (state_reg == ST_RUN);
    assign x_more = (x_cnt_reg < X_END);
    assign f_more = (f_cnt_reg < F_END);
    assign y_room = (y_cnt_reg < Y_END);

    assign busy = run;
    assign done = (state_reg == ST_FIN);

    assign m_data_out_x = xbuf[x_cnt_reg[LOGX-1:0]];
    assign m_data_out_f = fbuf[f_cnt_reg[LOGF-1:0]];

`ifdef CONV_HOST_THROTTLE_EN
    logic [15:0] lfsr_reg;
    logic        vx_reg;
    logic        vf_reg;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr_reg <= 16'hACE1;
        else
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    // Valid may only rise on a permitting LFSR bit, but never falls before its handshake.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            vx_reg <= 1'b0;
            vf_reg <= 1'b0;
        end else begin
            if (vx_reg) begin
                if (m_ready_x)
                    vx_reg <= 1'b0;
            end else if (x_more && lfsr_reg[0]) begin
                vx_reg <= 1'b1;
            end
            if (vf_reg) begin
                if (m_ready_f)
                    vf_reg <= 1'b0;
            end else if (f_more && lfsr_reg[1]) begin
                vf_reg <= 1'b1;
            end
        end
    end

    assign m_valid_x = vx_reg;
    assign m_valid_f = vf_reg;
    assign s_ready_y = run && y_room && lfsr_reg[2];
`else
    assign m_valid_x = run && x_more;
    assign m_valid_f = run && f_more;
    assign s_ready_y = run && y_room;
`endif

    assign x_fire = m_valid_x && m_ready_x;
    assign f_fire = m_valid_f && m_ready_f;
    assign y_fire = s_valid_y && s_ready_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            x_cnt_reg <= '0;
            f_cnt_reg <= '0;
            y_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_RUN;
                        x_cnt_reg <= '0;
                        f_cnt_reg <= '0;
                        y_cnt_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (x_fire)
                        x_cnt_reg <= x_cnt_reg + X_ONE;
                    if (f_fire)
                        f_cnt_reg <= f_cnt_reg + F_ONE;
                    if (y_fire)
                        y_cnt_reg <= y_cnt_reg + Y_ONE;
                    // Completion looks at the registered counts, so it lands one cycle after the last beat.
                    if (x_cnt_reg == X_END && f_cnt_reg == F_END && y_cnt_reg == Y_END)
                        state_reg <= ST_FIN;
                end
                ST_FIN: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Vector loads are only honoured while idle; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && ld_en) begin
            if (!ld_sel && ({1'b0, ld_addr} < X_END))
                xbuf[ld_addr] <= ld_data;
            if (ld_sel && ({1'b0, ld_addr} < XF_END))
                fbuf[ld_addr[LOGF-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (y_fire)
            ybuf[y_cnt_reg[LOGY-1:0]] <= s_data_in_y;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < Y_END)
            rd_data <= ybuf[rd_addr];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_conv_host_8_4.sv
// Randomized scoreboard bench for conv_host_8_4 with a behavioural convolver model on the far side.
module tb_conv_host_8_4;

    localparam int XLEN = 8;
    localparam int FLEN = 4;
    localparam int YLEN = XLEN - FLEN + 1;

    logic        clk;
    logic        reset;
    logic        ld_en;
    logic        ld_sel;
    logic [2:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        start;
    logic [7:0]  m_data_out_x;
    logic        m_valid_x;
    logic        m_ready_x;
    logic [7:0]  m_data_out_f;
    logic        m_valid_f;
    logic        m_ready_f;
    logic [17:0] s_data_in_y;
    logic        s_valid_y;
    logic        s_ready_y;
    logic [2:0]  rd_addr;
    logic [17:0] rd_data;
    logic        busy;
    logic        done;

    conv_host_8_4 dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start),
        .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
        .m_data_out_f(m_data_out_f), .m_valid_f(m_valid_f), .m_ready_f(m_ready_f),
        .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    int xm[XLEN];
    int fm[FLEN];
    int yexp[YLEN];

    logic [7:0] exp_x[$];
    logic [7:0] exp_f[$];
    int         y_q[$];

    int y_idx = 0;
    bit y_took = 0;
    bit y_en = 0;
    bit hold = 0;
    int rmode = 0;
    int x_stall = 0;
    int x_beats = 0;
    int f_beats = 0;
    int done_cnt = 0;
    int run_d0, run_bx0, run_bf0;

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Sinks for the x and f streams.
    initial begin
        m_ready_x = 1'b0;
        m_ready_f = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold) begin
                m_ready_x = 1'b0;
                m_ready_f = 1'b0;
            end else begin
                if (x_stall > 0) begin
                    m_ready_x = 1'b0;
                    x_stall--;
                end else begin
                    m_ready_x = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
                m_ready_f = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    // x stream monitor: data order and hold-until-handshake.
    initial begin
        logic [7:0] x_last;
        bit x_pend;
        x_pend = 0;
        x_last = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                x_pend = 0;
            end else begin
                if (x_pend) begin
                    chk("x_valid_held", m_valid_x, 1);
                    chk("x_data_held", m_data_out_x, x_last);
                end
                if (m_valid_x && m_ready_x) begin
                    x_beats++;
                    if (exp_x.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL x_extra_beat: got beat %0d, expected none", m_data_out_x);
                    end else begin
                        chk("x_data", m_data_out_x, exp_x.pop_front());
                    end
                    x_pend = 0;
                end else if (m_valid_x) begin
                    x_pend = 1;
                    x_last = m_data_out_x;
                end else begin
                    x_pend = 0;
                end
            end
        end
    end

    // f stream monitor.
    initial begin
        logic [7:0] f_last;
        bit f_pend;
        f_pend = 0;
        f_last = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                f_pend = 0;
            end else begin
                if (f_pend) begin
                    chk("f_valid_held", m_valid_f, 1);
                    chk("f_data_held", m_data_out_f, f_last);
                end
                if (m_valid_f && m_ready_f) begin
                    f_beats++;
                    if (exp_f.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL f_extra_beat: got beat %0d, expected none", m_data_out_f);
                    end else begin
                        chk("f_data", m_data_out_f, exp_f.pop_front());
                    end
                    f_pend = 0;
                end else if (m_valid_f) begin
                    f_pend = 1;
                    f_last = m_data_out_f;
                end else begin
                    f_pend = 0;
                end
            end
        end
    end

    // y source: the convolver model returns its results independently of the x/f progress.
    initial begin
        s_valid_y = 1'b0;
        s_data_in_y = '0;
        forever begin
            @(posedge clk); #1;
            if (hold || !y_en) begin
                s_valid_y = 1'b0;
            end else if (s_valid_y && !y_took) begin
                s_valid_y = 1'b1;
            end else if (y_idx < y_q.size() && (rmode == 0 || $urandom_range(0, 3) != 0)) begin
                s_valid_y = 1'b1;
                s_data_in_y = 18'(y_q[y_idx]);
            end else begin
                s_valid_y = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (s_valid_y && y_idx >= YLEN)
                chk("y_ready_after_full", s_ready_y, 0);
            y_took = s_valid_y && s_ready_y;
            if (y_took)
                y_idx++;
            if (done) begin
                done_cnt++;
                chk("busy_during_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic load(input bit sel, input int a, input int v);
        tick();
        ld_en = 1'b1;
        ld_sel = sel;
        ld_addr = 3'(a);
        ld_data = 8'(v);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < XLEN; i++) load(1'b0, i, xm[i]);
        for (int j = 0; j < FLEN; j++) load(1'b1, j, fm[j]);
    endtask

    // Reference: y[k] = sum_j x[k+j] * f[j].
    task automatic calc_ref();
        for (int k = 0; k < YLEN; k++) begin
            yexp[k] = 0;
            for (int j = 0; j < FLEN; j++) yexp[k] += xm[k + j] * fm[j];
        end
    endtask

    task automatic randomize_vectors();
        for (int i = 0; i < XLEN; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < FLEN; j++) fm[j] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic set_test_vectors();
        int xv[XLEN];
        int fv[FLEN];
        xv = '{10, -20, 30, -40, 50, 60, 70, 80};
        fv = '{10, 20, -30, 40};
        xm = xv;
        fm = fv;
    endtask

    task automatic begin_run(input int extra);
        exp_x.delete();
        exp_f.delete();
        y_q.delete();
        for (int i = 0; i < XLEN; i++) exp_x.push_back(8'(xm[i]));
        for (int j = 0; j < FLEN; j++) exp_f.push_back(8'(fm[j]));
        for (int k = 0; k < YLEN; k++) y_q.push_back(yexp[k]);
        for (int e = 0; e < extra; e++) y_q.push_back(int'($urandom_range(0, 4095)));
        y_idx = 0;
        y_took = 0;
        y_en = 1;
        run_d0 = done_cnt;
        run_bx0 = x_beats;
        run_bf0 = f_beats;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_x_beats(input int n);
        int c;
        c = 0;
        while (x_beats - run_bx0 < n && c < 300) begin
            tick();
            c++;
        end
        chk("x_beats_reached", x_beats - run_bx0, n);
    endtask

    task automatic finish_run(input string tag);
        int c;
        c = 0;
        while (done_cnt == run_d0 && c < 600) begin
            tick();
            c++;
        end
        repeat (4) tick();
        chk({tag, "_done_pulses"}, done_cnt - run_d0, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_x_beats"}, x_beats - run_bx0, XLEN);
        chk({tag, "_f_beats"}, f_beats - run_bf0, FLEN);
        chk({tag, "_x_left"}, exp_x.size(), 0);
        chk({tag, "_f_left"}, exp_f.size(), 0);
        chk({tag, "_y_accepted"}, y_idx, YLEN);
        y_en = 0;
        for (int a = 0; a < 8; a++) begin
            tick();
            rd_addr = 3'(a);
            tick();
            chk($sformatf("%s_ybuf_%0d", tag, a), $signed(rd_data), (a < YLEN) ? yexp[a] : 0);
        end
        $display("run %s complete: %0d checks, %0d failures so far", tag, n_chk, n_fail);
    endtask

    initial begin
        reset = 1'b1;
        ld_en = 1'b0;
        ld_sel = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        start = 1'b0;
        rd_addr = '0;
        repeat (3) tick();
        chk("rst_valid_x", m_valid_x, 0);
        chk("rst_valid_f", m_valid_f, 0);
        chk("rst_ready_y", s_ready_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Known vectors, full-rate streams, results against the hand-computed table.
        set_test_vectors();
        load_all();
        yexp = '{-2800, 3600, 400, 1600, 2800};
        rmode = 0;
        begin_run(0);
        finish_run("basic");

        // x stall mid-stream, six y beats offered, load/start attempts while running.
        randomize_vectors();
        load_all();
        calc_ref();
        begin_run(1);
        wait_x_beats(3);
        x_stall = 5;
        tick();
        ld_en = 1'b1;
        ld_sel = 1'b0;
        ld_addr = 3'd7;
        ld_data = ~8'(xm[7]);
        start = 1'b1;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        chk("busy_in_run", busy, 1);
        finish_run("stall");

        // Second run after done with a new f vector.
        set_test_vectors();
        load_all();
        fm = '{-50, -60, 70, 80};
        for (int j = 0; j < FLEN; j++) load(1'b1, j, fm[j]);
        calc_ref();
        rmode = 1;
        begin_run(0);
        finish_run("newf");

        // Reset after three x beats, then replay.
        randomize_vectors();
        load_all();
        calc_ref();
        begin_run(0);
        wait_x_beats(3);
        hold = 1;
        m_ready_x = 1'b0;
        m_ready_f = 1'b0;
        s_valid_y = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_valid_x", m_valid_x, 0);
        chk("midrst_valid_f", m_valid_f, 0);
        chk("midrst_ready_y", s_ready_y, 0);
        chk("midrst_busy", busy, 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("midrst_no_done", done_cnt - run_d0, 0);
        hold = 0;
        begin_run(0);
        finish_run("replay");

        // Known vectors again under random back-pressure.
        set_test_vectors();
        load_all();
        yexp = '{-2800, 3600, 400, 1600, 2800};
        begin_run(0);
        finish_run("randbp");

        for (int r = 0; r < 3; r++) begin
            randomize_vectors();
            load_all();
            calc_ref();
            begin_run(0);
            finish_run($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
